// File: rtl/stopwatch_core.sv
// stopwatch_core: mm:ss.t stopwatch counting 0.1 s steps derived from a
// tick_in strobe, with run/stop, lap-freeze and clear commands.
//
// Ports
//   clk        system clock; all state updates on its rising edge
//   rst_n      synchronous active-low reset
//   tick_in    tick square wave (clk domain); each rising edge is one tick
//   start_stop start/stop command level (rising edge = command)
//   lap        lap command level (rising edge = command)
//   clear      clear command level (rising edge = command, honoured in STOP)
//   tenths     displayed tenths, BCD 0..9
//   secs_ones  displayed seconds units, BCD 0..9
//   secs_tens  displayed seconds tens, 0..5
//   mins_ones  displayed minutes units, BCD 0..9
//   mins_tens  displayed minutes tens, 0..5
//   running    high in RUN or LAP
//   lap_hold   high in LAP (display frozen)
//   wrap       one-cycle pulse after the 59:59.9 -> 00:00.0 rollover
`timescale 1ns/1ps
module stopwatch_core #(
    parameter int unsigned TICKS_PER_TENTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] tenths,
    output logic [3:0] secs_ones,
    output logic [2:0] secs_tens,
    output logic [3:0] mins_ones,
    output logic [2:0] mins_tens,
    output logic       running,
    output logic       lap_hold,
    output logic       wrap
);

    localparam logic [7:0] PRE_MAX = 8'(TICKS_PER_TENTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAP,
        S_STOP
    } state_t;

    state_t     state_q, state_d;

    // Input history; reset to 1 so levels held through reset are not edges.
    logic       tick_h_q, ss_h_q, lap_h_q, clr_h_q;
    logic       tick_edge, ss_edge, lap_edge, clr_edge;

    logic [7:0] pre_q, pre_d;

    logic [3:0] cnt_t_q, cnt_t_d;
    logic [3:0] cnt_so_q, cnt_so_d;
    logic [2:0] cnt_st_q, cnt_st_d;
    logic [3:0] cnt_mo_q, cnt_mo_d;
    logic [2:0] cnt_mt_q, cnt_mt_d;

    logic [3:0] dsp_t_q, dsp_t_d;
    logic [3:0] dsp_so_q, dsp_so_d;
    logic [2:0] dsp_st_q, dsp_st_d;
    logic [3:0] dsp_mo_q, dsp_mo_d;
    logic [2:0] dsp_mt_q, dsp_mt_d;

    logic       running_q, running_d;
    logic       lap_hold_q, lap_hold_d;
    logic       wrap_q, wrap_d;

    logic       counting;
    logic       clear_now;

    assign tick_edge = tick_in    & ~tick_h_q;
    assign ss_edge   = start_stop & ~ss_h_q;
    assign lap_edge  = lap        & ~lap_h_q;
    assign clr_edge  = clear      & ~clr_h_q;

    assign counting  = (state_q == S_RUN) || (state_q == S_LAP);
    assign clear_now = (state_q == S_STOP) && clr_edge;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (ss_edge) state_d = S_RUN;
            S_RUN: begin
                if (ss_edge)       state_d = S_STOP;
                else if (lap_edge) state_d = S_LAP;
            end
            S_LAP: begin
                if (ss_edge)       state_d = S_STOP;
                else if (lap_edge) state_d = S_RUN;
            end
            S_STOP: begin
                if (clr_edge)     state_d = S_IDLE;
                else if (ss_edge) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counting depends on the current state only, so the tick that arrives
    // alongside a stop command is still counted.
    always_comb begin
        pre_d    = pre_q;
        cnt_t_d  = cnt_t_q;
        cnt_so_d = cnt_so_q;
        cnt_st_d = cnt_st_q;
        cnt_mo_d = cnt_mo_q;
        cnt_mt_d = cnt_mt_q;
        wrap_d   = 1'b0;

        if (counting && tick_edge) begin
            if (pre_q == PRE_MAX) begin
                pre_d = '0;
                if (cnt_t_q != 4'd9) begin
                    cnt_t_d = cnt_t_q + 4'd1;
                end else begin
                    cnt_t_d = '0;
                    if (cnt_so_q != 4'd9) begin
                        cnt_so_d = cnt_so_q + 4'd1;
                    end else begin
                        cnt_so_d = '0;
                        if (cnt_st_q != 3'd5) begin
                            cnt_st_d = cnt_st_q + 3'd1;
                        end else begin
                            cnt_st_d = '0;
                            if (cnt_mo_q != 4'd9) begin
                                cnt_mo_d = cnt_mo_q + 4'd1;
                            end else begin
                                cnt_mo_d = '0;
                                if (cnt_mt_q != 3'd5) begin
                                    cnt_mt_d = cnt_mt_q + 3'd1;
                                end else begin
                                    cnt_mt_d = '0;
                                    wrap_d   = 1'b1;
                                end
                            end
                        end
                    end
                end
            end else begin
                pre_d = pre_q + 8'd1;
            end
        end

        if (clear_now) begin
            pre_d    = '0;
            cnt_t_d  = '0;
            cnt_so_d = '0;
            cnt_st_d = '0;
            cnt_mo_d = '0;
            cnt_mt_d = '0;
        end
    end

    // Display trails the count by one cycle; freezing keys off the next
    // state so the value shown at LAP entry is the one held.
    always_comb begin
        if (clear_now) begin
            dsp_t_d  = '0;
            dsp_so_d = '0;
            dsp_st_d = '0;
            dsp_mo_d = '0;
            dsp_mt_d = '0;
        end else if (state_d == S_LAP) begin
            dsp_t_d  = dsp_t_q;
            dsp_so_d = dsp_so_q;
            dsp_st_d = dsp_st_q;
            dsp_mo_d = dsp_mo_q;
            dsp_mt_d = dsp_mt_q;
        end else begin
            dsp_t_d  = cnt_t_q;
            dsp_so_d = cnt_so_q;
            dsp_st_d = cnt_st_q;
            dsp_mo_d = cnt_mo_q;
            dsp_mt_d = cnt_mt_q;
        end
        running_d  = (state_d == S_RUN) || (state_d == S_LAP);
        lap_hold_d = (state_d == S_LAP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tick_h_q   <= 1'b1;
            ss_h_q     <= 1'b1;
            lap_h_q    <= 1'b1;
            clr_h_q    <= 1'b1;
            pre_q      <= '0;
            cnt_t_q    <= '0;
            cnt_so_q   <= '0;
            cnt_st_q   <= '0;
            cnt_mo_q   <= '0;
            cnt_mt_q   <= '0;
            dsp_t_q    <= '0;
            dsp_so_q   <= '0;
            dsp_st_q   <= '0;
            dsp_mo_q   <= '0;
            dsp_mt_q   <= '0;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_h_q   <= tick_in;
            ss_h_q     <= start_stop;
            lap_h_q    <= lap;
            clr_h_q    <= clear;
            pre_q      <= pre_d;
            cnt_t_q    <= cnt_t_d;
            cnt_so_q   <= cnt_so_d;
            cnt_st_q   <= cnt_st_d;
            cnt_mo_q   <= cnt_mo_d;
            cnt_mt_q   <= cnt_mt_d;
            dsp_t_q    <= dsp_t_d;
            dsp_so_q   <= dsp_so_d;
            dsp_st_q   <= dsp_st_d;
            dsp_mo_q   <= dsp_mo_d;
            dsp_mt_q   <= dsp_mt_d;
            running_q  <= running_d;
            lap_hold_q <= lap_hold_d;
            wrap_q     <= wrap_d;
        end
    end

    assign tenths    = dsp_t_q;
    assign secs_ones = dsp_so_q;
    assign secs_tens = dsp_st_q;
    assign mins_ones = dsp_mo_q;
    assign mins_tens = dsp_mt_q;
    assign running   = running_q;
    assign lap_hold  = lap_hold_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed bench for stopwatch_core. Instance dut uses
// TICKS_PER_TENTH=2; instance dutw uses TICKS_PER_TENTH=1 so the full
// 59:59.9 rollover is reachable in a modest number of cycles.
`timescale 1ns/1ps
module tb_stopwatch_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Main instance
    logic       rst_n = 1'b0, tick = 1'b0, ss = 1'b0, lp = 1'b0, clr = 1'b0;
    logic [3:0] t, so, mo;
    logic [2:0] st, mt;
    logic       running, lap_hold, wrap;
    logic [17:0] disp;
    assign disp = {mt, mo, st, so, t};

    stopwatch_core #(.TICKS_PER_TENTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .tick_in(tick), .start_stop(ss),
        .lap(lp), .clear(clr), .tenths(t), .secs_ones(so), .secs_tens(st),
        .mins_ones(mo), .mins_tens(mt), .running(running),
        .lap_hold(lap_hold), .wrap(wrap)
    );

    // Rollover instance
    logic       rst_n_w = 1'b0, tick_w = 1'b0, ss_w = 1'b0, lp_w = 1'b0, clr_w = 1'b0;
    logic [3:0] t_w, so_w, mo_w;
    logic [2:0] st_w, mt_w;
    logic       running_w, lap_hold_w, wrap_w;
    logic [17:0] disp_w;
    assign disp_w = {mt_w, mo_w, st_w, so_w, t_w};

    stopwatch_core #(.TICKS_PER_TENTH(1)) dutw (
        .clk(clk), .rst_n(rst_n_w), .tick_in(tick_w), .start_stop(ss_w),
        .lap(lp_w), .clear(clr_w), .tenths(t_w), .secs_ones(so_w),
        .secs_tens(st_w), .mins_ones(mo_w), .mins_tens(mt_w),
        .running(running_w), .lap_hold(lap_hold_w), .wrap(wrap_w)
    );

    function automatic logic [17:0] mk(input int m10, input int m1,
                                       input int s10, input int s1,
                                       input int d);
        return {3'(m10), 4'(m1), 3'(s10), 4'(s1), 4'(d)};
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
    endtask

    task automatic press_ss();
        ss = 1'b1; cyc();
        ss = 1'b0; cyc();
    endtask

    task automatic press_lap();
        lp = 1'b1; cyc();
        lp = 1'b0; cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cyc(); cyc();
        rst_n = 1'b1; cyc();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (disp !== 18'd0) begin bad++; $display("FAIL reset_disp got=%h want=%h", disp, 18'd0); end
        total++; if ({running, lap_hold, wrap} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {running, lap_hold, wrap}); end
        // IDLE ignores ticks and lap
        tick_pulse(4);
        press_lap();
        total++; if (disp !== 18'd0) begin bad++; $display("FAIL idle_ticks got=%h want=%h", disp, 18'd0); end
        total++; if ({running, lap_hold} !== 2'b00) begin bad++; $display("FAIL idle_lap got=%b want=00", {running, lap_hold}); end
    endtask

    task automatic test_count();
        press_ss();
        total++; if ({running, lap_hold} !== 2'b10) begin bad++; $display("FAIL start_run got=%b want=10", {running, lap_hold}); end
        tick_pulse(1);
        total++; if (disp !== 18'd0) begin bad++; $display("FAIL prescale_first got=%h want=%h", disp, 18'd0); end
        // second tick: count updates at the sampling edge, display one edge later
        tick = 1'b1; cyc();
        total++; if (disp !== 18'd0) begin bad++; $display("FAIL latency_early got=%h want=%h", disp, 18'd0); end
        tick = 1'b0; cyc();
        total++; if (disp !== mk(0,0,0,0,1)) begin bad++; $display("FAIL latency_late got=%h want=%h", disp, mk(0,0,0,0,1)); end
        tick_pulse(18);
        total++; if (disp !== mk(0,0,0,1,0)) begin bad++; $display("FAIL count_1s got=%h want=%h", disp, mk(0,0,0,1,0)); end
        total++; if (running !== 1'b1) begin bad++; $display("FAIL count_running got=%b want=1", running); end
    endtask

    task automatic test_lap();
        tick_pulse(40);
        total++; if (disp !== mk(0,0,0,3,0)) begin bad++; $display("FAIL lap_pre got=%h want=%h", disp, mk(0,0,0,3,0)); end
        press_lap();
        total++; if ({running, lap_hold} !== 2'b11) begin bad++; $display("FAIL lap_enter got=%b want=11", {running, lap_hold}); end
        tick_pulse(10);
        total++; if (disp !== mk(0,0,0,3,0)) begin bad++; $display("FAIL lap_frozen got=%h want=%h", disp, mk(0,0,0,3,0)); end
        total++; if (lap_hold !== 1'b1) begin bad++; $display("FAIL lap_hold_still got=%b want=1", lap_hold); end
        press_lap();
        total++; if (disp !== mk(0,0,0,3,5)) begin bad++; $display("FAIL lap_release got=%h want=%h", disp, mk(0,0,0,3,5)); end
        total++; if ({running, lap_hold} !== 2'b10) begin bad++; $display("FAIL lap_exit got=%b want=10", {running, lap_hold}); end
        // leave prescaler at 1, then start_stop and lap together: stop wins
        tick_pulse(1);
        ss = 1'b1; lp = 1'b1; cyc();
        ss = 1'b0; lp = 1'b0; cyc();
        total++; if ({running, lap_hold} !== 2'b00) begin bad++; $display("FAIL ss_beats_lap got=%b want=00", {running, lap_hold}); end
        tick_pulse(6);
        total++; if (disp !== mk(0,0,0,3,5)) begin bad++; $display("FAIL stop_hold got=%h want=%h", disp, mk(0,0,0,3,5)); end
        press_ss();
        tick_pulse(1);
        total++; if (disp !== mk(0,0,0,3,6)) begin bad++; $display("FAIL resume_prescaler got=%h want=%h", disp, mk(0,0,0,3,6)); end
        // LAP -> STOP shows the live count
        press_lap();
        tick_pulse(4);
        press_ss();
        total++; if (disp !== mk(0,0,0,3,8)) begin bad++; $display("FAIL lap_to_stop got=%h want=%h", disp, mk(0,0,0,3,8)); end
        total++; if ({running, lap_hold} !== 2'b00) begin bad++; $display("FAIL lap_to_stop_flags got=%b want=00", {running, lap_hold}); end
    endtask

    task automatic test_clear();
        do_reset();
        press_ss();
        tick_pulse(48);
        total++; if (disp !== mk(0,0,0,2,4)) begin bad++; $display("FAIL clear_pre got=%h want=%h", disp, mk(0,0,0,2,4)); end
        // clear in RUN is ignored
        clr = 1'b1; cyc(); clr = 1'b0; cyc();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL clear_in_run got=%b want=1", running); end
        press_ss();
        total++; if (disp !== mk(0,0,0,2,4)) begin bad++; $display("FAIL stop_at_2_4 got=%h want=%h", disp, mk(0,0,0,2,4)); end
        clr = 1'b1; ss = 1'b1; cyc();
        clr = 1'b0; ss = 1'b0; cyc();
        total++; if (disp !== 18'd0) begin bad++; $display("FAIL clear_disp got=%h want=%h", disp, 18'd0); end
        total++; if ({running, lap_hold, wrap} !== 3'b000) begin bad++; $display("FAIL clear_flags got=%b want=000", {running, lap_hold, wrap}); end
        tick_pulse(2);
        total++; if (disp !== 18'd0) begin bad++; $display("FAIL clear_is_idle got=%h want=%h", disp, 18'd0); end
        // prescaler was zeroed: two ticks give exactly one step
        press_ss();
        tick_pulse(2);
        total++; if (disp !== mk(0,0,0,0,1)) begin bad++; $display("FAIL clear_prescaler got=%h want=%h", disp, mk(0,0,0,0,1)); end
    endtask

    task automatic test_reset_held();
        ss = 1'b1;
        rst_n = 1'b0; cyc(); cyc();
        rst_n = 1'b1; cyc(); cyc();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL held_ss_idle got=%b want=0", running); end
        ss = 1'b0; cyc();
        ss = 1'b1; cyc();
        total++; if (running !== 1'b1) begin bad++; $display("FAIL held_ss_new_edge got=%b want=1", running); end
        ss = 1'b0; cyc();
    endtask

    task automatic test_reset_mid_run();
        tick_pulse(1668);
        total++; if (disp !== mk(0,1,2,3,4)) begin bad++; $display("FAIL run_1_23_4 got=%h want=%h", disp, mk(0,1,2,3,4)); end
        rst_n = 1'b0; cyc();
        total++; if (disp !== 18'd0) begin bad++; $display("FAIL midrun_reset_disp got=%h want=%h", disp, 18'd0); end
        total++; if ({running, lap_hold, wrap} !== 3'b000) begin bad++; $display("FAIL midrun_reset_flags got=%b want=000", {running, lap_hold, wrap}); end
        rst_n = 1'b1; cyc();
        tick_pulse(4);
        total++; if (disp !== 18'd0) begin bad++; $display("FAIL post_reset_ticks got=%h want=%h", disp, 18'd0); end
    endtask

    task automatic test_wrap();
        int early;
        early = 0;
        rst_n_w = 1'b0; cyc(); cyc();
        rst_n_w = 1'b1; cyc();
        ss_w = 1'b1; cyc(); ss_w = 1'b0; cyc();
        for (int i = 0; i < 35999; i++) begin
            tick_w = 1'b1; cyc();
            if (wrap_w) early++;
            tick_w = 1'b0; cyc();
            if (wrap_w) early++;
        end
        total++; if (early !== 0) begin bad++; $display("FAIL wrap_early got=%0d want=0", early); end
        total++; if (disp_w !== mk(5,9,5,9,9)) begin bad++; $display("FAIL wrap_pre got=%h want=%h", disp_w, mk(5,9,5,9,9)); end
        tick_w = 1'b1; cyc();
        total++; if (wrap_w !== 1'b1) begin bad++; $display("FAIL wrap_pulse got=%b want=1", wrap_w); end
        tick_w = 1'b0; cyc();
        total++; if (wrap_w !== 1'b0) begin bad++; $display("FAIL wrap_one_cycle got=%b want=0", wrap_w); end
        total++; if (disp_w !== 18'd0) begin bad++; $display("FAIL wrap_disp got=%h want=%h", disp_w, 18'd0); end
        total++; if (running_w !== 1'b1) begin bad++; $display("FAIL wrap_running got=%b want=1", running_w); end
        tick_w = 1'b1; cyc(); tick_w = 1'b0; cyc();
        total++; if (disp_w !== mk(0,0,0,0,1)) begin bad++; $display("FAIL wrap_continue got=%h want=%h", disp_w, mk(0,0,0,0,1)); end
    endtask

    initial begin
        cyc();
        test_reset();
        test_count();
        test_lap();
        test_clear();
        test_reset_held();
        test_reset_mid_run();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
